// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial 32-bit adder/subtractor.
// One 4-bit carry-lookahead slice is reused for eight cycles, working from the
// least significant nibble upward, and the full result is published at the end.

// 4-bit carry-lookahead slice. It returns the nibble sum and the group
// generate/propagate pair, so the caller can form the group carry-out.
module adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       g_o,
  output logic       p_o
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] carry;

  // Bit generate/propagate, lookahead carries and the group G/P terms
  always_comb begin
    gen      = a_i & b_i;
    prop     = a_i ^ b_i;
    carry[0] = c_i;
    carry[1] = gen[0] | (prop[0] & c_i);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c_i);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & c_i);
    s_o      = prop ^ carry;
    g_o      = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0]);
    p_o      = &prop;
  end

endmodule

// Controller: accepts an operation, walks the eight nibbles through the slice
// and raises done for one cycle once sum, cout and ovf have been updated.
module nibble_serial_adder_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        sub_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] sum_o,
  output logic        cout_o,
  output logic        ovf_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] opA_q, opA_d;
  logic [31:0] opB_q, opB_d;
  logic        carry_q, carry_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  nibA;
  logic [3:0]  nibB;
  logic [3:0]  nibSum;
  logic        nibG;
  logic        nibP;
  logic        nibCarry;

  adder_4bit u_slice (
    .a_i (nibA),
    .b_i (nibB),
    .c_i (carry_q),
    .s_o (nibSum),
    .g_o (nibG),
    .p_o (nibP)
  );

  // Select the current nibble of the latched operands and form its carry-out
  always_comb begin
    nibA     = opA_q[{cnt_q, 2'b00} +: 4];
    nibB     = opB_q[{cnt_q, 2'b00} +: 4];
    nibCarry = nibG | (nibP & carry_q);
  end

  // Next-state logic: operand capture in IDLE, one nibble per cycle in RUN,
  // and the result published on the final RUN edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          cnt_d   = 3'd0;
          opA_d   = a_i;
          opB_d   = sub_i ? ~b_i : b_i;
          carry_d = sub_i | cin_i;
          acc_d   = 32'd0;
        end
      end
      RUN: begin
        acc_d   = {nibSum, acc_q[31:4]};
        carry_d = nibCarry;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          sum_d   = {nibSum, acc_q[31:4]};
          cout_d  = nibCarry;
          ovf_d   = (opA_q[31] == opB_q[31]) && (nibSum[3] != opA_q[31]);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      opA_q   <= 32'd0;
      opB_q   <= 32'd0;
      carry_q <= 1'b0;
      acc_q   <= 32'd0;
      sum_q   <= 32'd0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status flags are decoded from the state; results come straight from registers
  always_comb begin
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
    sum_o  = sum_q;
    cout_o = cout_q;
    ovf_o  = ovf_q;
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl: directed operations checked against a
// cycle-level behavioural model plus literal expected results.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        startIn = 1'b0;
  logic        subIn = 1'b0;
  logic [31:0] aIn = 32'd0;
  logic [31:0] bIn = 32'd0;
  logic        cinIn = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] sum_o;
  logic        cout_o;
  logic        ovf_o;

  int compared = 0;
  int mismatched = 0;
  bit checkEn = 1'b0;
  int lastAcceptTries = 0;

  // Model state: phase 0 = idle, 1..8 = busy cycles, 9 = done cycle
  int          phase = 0;
  logic [33:0] pending = 34'd0;
  logic [31:0] expSum = 32'd0;
  logic        expCout = 1'b0;
  logic        expOvf = 1'b0;

  nibble_serial_adder_ctrl dut (
    .clk     (clk),
    .rst_n   (rstN),
    .start_i (startIn),
    .sub_i   (subIn),
    .a_i     (aIn),
    .b_i     (bIn),
    .cin_i   (cinIn),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  // Plain 33-bit arithmetic result packed as {ovf, cout, sum}
  function automatic logic [33:0] calcResult(input logic [31:0] a, input logic [31:0] b,
                                             input logic cin, input logic sub);
    logic [31:0] bEff;
    logic        cEff;
    logic [32:0] full;
    logic        ovf;
    bEff = sub ? ~b : b;
    cEff = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bEff} + {32'd0, cEff};
    ovf  = (a[31] == bEff[31]) && (full[31] != a[31]);
    return {ovf, full[32], full[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural timeline: accept, eight busy cycles, one done cycle, result visible from done
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      phase   <= 0;
      pending <= 34'd0;
      expSum  <= 32'd0;
      expCout <= 1'b0;
      expOvf  <= 1'b0;
    end else if (phase == 0) begin
      if (startIn) begin
        phase   <= 1;
        pending <= calcResult(aIn, bIn, cinIn, subIn);
      end
    end else if (phase < 8) begin
      phase <= phase + 1;
    end else if (phase == 8) begin
      phase   <= 9;
      expSum  <= pending[31:0];
      expCout <= pending[32];
      expOvf  <= pending[33];
    end else begin
      phase <= 0;
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 32'(busy_o), 32'(phase >= 1 && phase <= 8));
      checkOutput("done", 32'(done_o), 32'(phase == 9));
      checkOutput("sum", sum_o, expSum);
      checkOutput("cout", 32'(cout_o), 32'(expCout));
      checkOutput("ovf", 32'(ovf_o), 32'(expOvf));
      checkOutput("busyDoneExcl", 32'(busy_o & done_o), 32'd0);
    end
  end

  // Issue one operation and check latency, busy length and the literal result.
  // With disturb set, inputs are scrambled after acceptance and start is re-pulsed mid-run.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic sub, input bit disturb, input logic [31:0] wantSum,
                               input logic wantCout, input logic wantOvf);
    bit accepted;
    int busyCycles;
    int doneAt;
    aIn = a; bIn = b; cinIn = cin; subIn = sub; startIn = 1'b1;
    accepted = 1'b0;
    lastAcceptTries = 0;
    for (int i = 0; i < 4 && !accepted; i++) begin
      @(negedge clk);
      lastAcceptTries++;
      if (busy_o) accepted = 1'b1;
    end
    startIn = 1'b0;
    checkOutput("accept", 32'(accepted), 32'd1);
    busyCycles = 1;
    doneAt = 0;
    for (int n = 2; n <= 20 && doneAt == 0; n++) begin
      if (disturb && n == 3) begin
        aIn = $urandom; bIn = $urandom; cinIn = ~cin; subIn = ~sub; startIn = 1'b1;
      end
      if (disturb && n == 4) startIn = 1'b0;
      @(negedge clk);
      if (busy_o) busyCycles++;
      if (done_o) doneAt = n;
    end
    checkOutput("latency", 32'(doneAt), 32'd9);
    checkOutput("busyLen", 32'(busyCycles), 32'd8);
    checkOutput("litSum", sum_o, wantSum);
    checkOutput("litCout", 32'(cout_o), 32'(wantCout));
    checkOutput("litOvf", 32'(ovf_o), 32'(wantOvf));
  endtask

  // Watch a quiet stretch and require no completion pulse
  task automatic expectNoDone(input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done_o || busy_o) seen++;
    end
    checkOutput("noExtraActivity", 32'(seen), 32'd0);
  endtask

  initial begin
    // Reset values with reset held
    #12;
    checkOutput("rstBusy", 32'(busy_o), 32'd0);
    checkOutput("rstDone", 32'(done_o), 32'd0);
    checkOutput("rstSum", sum_o, 32'd0);
    checkOutput("rstCout", 32'(cout_o), 32'd0);
    checkOutput("rstOvf", 32'(ovf_o), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    checkEn = 1'b1;
    @(negedge clk);

    // Literal pins of the model
    checkOutput("modelAdd", calcResult(32'h0000_000F, 32'h1, 1'b0, 1'b0), {2'b00, 32'h0000_0010});
    checkOutput("modelSubOvf", calcResult(32'h8000_0000, 32'h1, 1'b0, 1'b1), {2'b11, 32'h7FFF_FFFF});

    applyStimulus(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    // Back-to-back: start raised in the done cycle is taken in the following idle cycle
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    checkOutput("backToBackTries", 32'(lastAcceptTries), 32'd2);
    applyStimulus(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b0, 32'h2222_2222, 1'b0, 1'b0);

    // Restart attempt and operand changes during a run
    @(negedge clk);
    applyStimulus(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b1, 32'h0000_3333, 1'b0, 1'b0);
    startIn = 1'b0;
    expectNoDone(12);

    // Reset pulse in the fourth busy cycle aborts the run
    aIn = 32'hAAAA_AAAA; bIn = 32'h5555_5555; cinIn = 1'b1; subIn = 1'b0; startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("abortBusy", 32'(busy_o), 32'd0);
    checkOutput("abortDone", 32'(done_o), 32'd0);
    checkOutput("abortSum", sum_o, 32'd0);
    checkOutput("abortCout", 32'(cout_o), 32'd0);
    checkOutput("abortOvf", 32'(ovf_o), 32'd0);
    #1 rstN = 1'b1;
    expectNoDone(12);
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
